// File: rtl/pudiannao_sel_pkg.sv
// Shared types for the PuDianNao result selector: source codes, FSM states
// and the default data width.
package pudiannao_sel_pkg;

    localparam int DW_DEF = 32;

    typedef enum logic [2:0] {
        SEL_NONE    = 3'b000,
        SEL_COUNTER = 3'b001,
        SEL_ADDER   = 3'b010,
        SEL_MULT    = 3'b011,
        SEL_ACC     = 3'b100,
        SEL_NONLIN  = 3'b101,
        SEL_KSORT   = 3'b110,
        SEL_BAD     = 3'b111
    } sel_e;

    typedef enum logic {
        IDLE,
        SEND
    } state_e;

    function automatic logic sel_legal(input logic [2:0] s);
        return (s != 3'b000) && (s != 3'b111);
    endfunction

endpackage

// File: rtl/ksort_beat_slicer.sv
// Picks the LANES-wide slice of the k-sort value or index array for a beat;
// lanes past the last element read as zero with a cleared mask bit.
module ksort_beat_slicer
    import pudiannao_sel_pkg::*;
#(
    parameter int DW     = DW_DEF,
    parameter int LANES  = 16,
    parameter int K      = 20,
    parameter int KBEATS = 2,
    parameter int BW     = 2
) (
    input  logic [K-1:0][DW-1:0]     vals,
    input  logic [K-1:0][DW-1:0]     idxs,
    input  logic [BW-1:0]            beat,
    output logic [LANES-1:0][DW-1:0] lanes,
    output logic [LANES-1:0]         mask,
    output logic                     is_index
);

    logic [DW-1:0] vpad [KBEATS][LANES];
    logic [DW-1:0] ipad [KBEATS][LANES];
    logic          mpad [KBEATS][LANES];
    logic [BW-1:0] bsel;

    // Pad both arrays to whole beats so every lane has a constant source.
    for (genvar e = 0; e < KBEATS * LANES; e++) begin : g_pad
        if (e < K) begin : g_in
            assign vpad[e/LANES][e%LANES] = vals[e];
            assign ipad[e/LANES][e%LANES] = idxs[e];
            assign mpad[e/LANES][e%LANES] = 1'b1;
        end else begin : g_out
            assign vpad[e/LANES][e%LANES] = '0;
            assign ipad[e/LANES][e%LANES] = '0;
            assign mpad[e/LANES][e%LANES] = 1'b0;
        end
    end

    always_comb begin
        is_index = (beat >= BW'(KBEATS));
        bsel     = is_index ? beat - BW'(KBEATS) : beat;
        lanes    = '0;
        mask     = '0;
        for (int b = 0; b < KBEATS; b++) begin
            if (bsel == BW'(b)) begin
                for (int j = 0; j < LANES; j++) begin
                    lanes[j] = is_index ? ipad[b][j] : vpad[b][j];
                    mask[j]  = mpad[b][j];
                end
            end
        end
    end

endmodule

// File: rtl/result_sel_stream.sv
// Back-end selector: snapshots one functional-unit result on start and
// streams it out as registered LANES-wide beats under valid/ready.
module result_sel_stream
    import pudiannao_sel_pkg::*;
#(
    parameter int DW       = DW_DEF,
    parameter int LANES    = 16,
    parameter int K        = 20,
    localparam int KBEATS  = (K + LANES - 1) / LANES,
    localparam int NBEATS  = 2 * KBEATS,
    localparam int BW      = (NBEATS > 2) ? $clog2(NBEATS) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [2:0]               sel,
    input  logic [LANES-1:0][DW-1:0] in_counter,
    input  logic [LANES-1:0][DW-1:0] in_adder,
    input  logic [LANES-1:0][DW-1:0] in_multiplier,
    input  logic [DW-1:0]            in_acc,
    input  logic [DW-1:0]            in_nonlin,
    input  logic [K-1:0][DW-1:0]     in_ksort,
    input  logic [K-1:0][DW-1:0]     in_ksort_index,
    output logic                     busy,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [LANES-1:0][DW-1:0] out_vector,
    output logic [DW-1:0]            out_scalar,
    output logic [LANES-1:0]         out_mask,
    output logic                     out_is_index,
    output logic                     out_last,
    output logic [BW-1:0]            out_beat,
    output logic                     err
);

    state_e                   state_q, state_d;
    logic [K-1:0][DW-1:0]     val_q, idx_q, val_n, idx_n;
    logic [BW-1:0]            beat_d;
    logic                     accept, fire;
    logic [LANES-1:0][DW-1:0] sl_vec, vec_d;
    logic [LANES-1:0]         sl_mask, mask_d;
    logic                     sl_idx, isidx_d;
    logic [DW-1:0]            sc_d;
    logic                     last_d, valid_d, busy_d, err_d;

    always_comb begin
        accept  = (state_q == IDLE) && start && sel_legal(sel);
        fire    = out_valid && out_ready;
        state_d = state_q;
        beat_d  = out_beat;
        val_n   = val_q;
        idx_n   = idx_q;
        if (accept && sel == SEL_KSORT) begin
            val_n = in_ksort;
            idx_n = in_ksort_index;
        end
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = SEND;
                    beat_d  = '0;
                end
            end
            SEND: begin
                if (fire) begin
                    if (out_last) begin
                        state_d = IDLE;
                        beat_d  = '0;
                    end else begin
                        beat_d = out_beat + BW'(1);
                    end
                end
            end
        endcase
    end

    // The slicer sees the freshly captured arrays on the start cycle.
    ksort_beat_slicer #(
        .DW     (DW),
        .LANES  (LANES),
        .K      (K),
        .KBEATS (KBEATS),
        .BW     (BW)
    ) u_slicer (
        .vals     (val_n),
        .idxs     (idx_n),
        .beat     (beat_d),
        .lanes    (sl_vec),
        .mask     (sl_mask),
        .is_index (sl_idx)
    );

    always_comb begin
        vec_d   = out_vector;
        sc_d    = out_scalar;
        mask_d  = out_mask;
        isidx_d = out_is_index;
        last_d  = out_last;
        valid_d = out_valid;
        busy_d  = busy;
        err_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                err_d = start && !sel_legal(sel);
                if (accept) begin
                    valid_d = 1'b1;
                    busy_d  = 1'b1;
                    last_d  = 1'b1;
                    isidx_d = 1'b0;
                    vec_d   = '0;
                    sc_d    = '0;
                    mask_d  = '0;
                    unique case (sel_e'(sel))
                        SEL_COUNTER: begin
                            vec_d  = in_counter;
                            mask_d = '1;
                        end
                        SEL_ADDER: begin
                            vec_d  = in_adder;
                            mask_d = '1;
                        end
                        SEL_MULT: begin
                            vec_d  = in_multiplier;
                            mask_d = '1;
                        end
                        SEL_ACC:    sc_d = in_acc;
                        SEL_NONLIN: sc_d = in_nonlin;
                        SEL_KSORT: begin
                            vec_d   = sl_vec;
                            mask_d  = sl_mask;
                            isidx_d = sl_idx;
                            last_d  = (beat_d == BW'(NBEATS - 1));
                        end
                        default: ;
                    endcase
                end
            end
            SEND: begin
                if (fire && out_last) begin
                    valid_d = 1'b0;
                    busy_d  = 1'b0;
                    last_d  = 1'b0;
                    isidx_d = 1'b0;
                    vec_d   = '0;
                    sc_d    = '0;
                    mask_d  = '0;
                end else if (fire) begin
                    vec_d   = sl_vec;
                    mask_d  = sl_mask;
                    isidx_d = sl_idx;
                    last_d  = (beat_d == BW'(NBEATS - 1));
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            val_q        <= '0;
            idx_q        <= '0;
            out_beat     <= '0;
            out_vector   <= '0;
            out_scalar   <= '0;
            out_mask     <= '0;
            out_is_index <= 1'b0;
            out_last     <= 1'b0;
            out_valid    <= 1'b0;
            busy         <= 1'b0;
            err          <= 1'b0;
        end else begin
            state_q      <= state_d;
            val_q        <= val_n;
            idx_q        <= idx_n;
            out_beat     <= beat_d;
            out_vector   <= vec_d;
            out_scalar   <= sc_d;
            out_mask     <= mask_d;
            out_is_index <= isidx_d;
            out_last     <= last_d;
            out_valid    <= valid_d;
            busy         <= busy_d;
            err          <= err_d;
        end
    end

endmodule

// File: tb/tb_result_sel_stream.sv
// Randomized scoreboard bench for result_sel_stream: stimulus pushes the
// expected beats, a negedge monitor pops and compares on every handshake.
module tb_result_sel_stream;
    import pudiannao_sel_pkg::*;

    localparam int DW    = 32;
    localparam int LANES = 16;
    localparam int K     = 20;
    localparam int KB    = (K + LANES - 1) / LANES;
    localparam int NB    = 2 * KB;
    localparam int BW    = (NB > 2) ? $clog2(NB) : 1;
    localparam int W     = LANES * DW;

    typedef logic [W-1:0] w_t;

    typedef struct {
        logic [LANES-1:0][DW-1:0] vec;
        logic [DW-1:0]            sc;
        logic [LANES-1:0]         mask;
        logic                     is_idx;
        logic                     last;
        logic [BW-1:0]            beat;
    } beat_t;

    logic                     clk;
    logic                     rst;
    logic                     start;
    logic [2:0]               sel;
    logic [LANES-1:0][DW-1:0] in_counter;
    logic [LANES-1:0][DW-1:0] in_adder;
    logic [LANES-1:0][DW-1:0] in_multiplier;
    logic [DW-1:0]            in_acc;
    logic [DW-1:0]            in_nonlin;
    logic [K-1:0][DW-1:0]     in_ksort;
    logic [K-1:0][DW-1:0]     in_ksort_index;
    logic                     busy;
    logic                     out_valid;
    logic                     out_ready;
    logic [LANES-1:0][DW-1:0] out_vector;
    logic [DW-1:0]            out_scalar;
    logic [LANES-1:0]         out_mask;
    logic                     out_is_index;
    logic                     out_last;
    logic [BW-1:0]            out_beat;
    logic                     err;

    result_sel_stream #(.DW(DW), .LANES(LANES), .K(K)) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .sel            (sel),
        .in_counter     (in_counter),
        .in_adder       (in_adder),
        .in_multiplier  (in_multiplier),
        .in_acc         (in_acc),
        .in_nonlin      (in_nonlin),
        .in_ksort       (in_ksort),
        .in_ksort_index (in_ksort_index),
        .busy           (busy),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_vector     (out_vector),
        .out_scalar     (out_scalar),
        .out_mask       (out_mask),
        .out_is_index   (out_is_index),
        .out_last       (out_last),
        .out_beat       (out_beat),
        .err            (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int    total = 0;
    int    bad   = 0;
    beat_t q[$];
    int    rmode = 3;
    int    rcnt  = 0;

    task automatic chk(input string nm, input w_t act, input w_t exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic beat_t blank();
        beat_t b;
        b.vec    = '0;
        b.sc     = '0;
        b.mask   = '0;
        b.is_idx = 1'b0;
        b.last   = 1'b0;
        b.beat   = '0;
        return b;
    endfunction

    task automatic randomize_src();
        for (int j = 0; j < LANES; j++) begin
            in_counter[j]    = $urandom;
            in_adder[j]      = $urandom;
            in_multiplier[j] = $urandom;
        end
        for (int i = 0; i < K; i++) begin
            in_ksort[i]       = $urandom;
            in_ksort_index[i] = $urandom;
        end
        in_acc    = $urandom;
        in_nonlin = $urandom;
    endtask

    // Reference: one beat for vector/scalar sources, 2*KB beats for k-sort.
    task automatic issue(input logic [2:0] s);
        beat_t exp[$];
        beat_t e;
        bit    idle;
        bit    legal;
        idle  = (q.size() == 0);
        legal = (s != 3'd0) && (s != 3'd7);
        if (idle && legal) begin
            e      = blank();
            e.last = 1'b1;
            case (s)
                3'd1: begin e.vec = in_counter;    e.mask = '1; exp.push_back(e); end
                3'd2: begin e.vec = in_adder;      e.mask = '1; exp.push_back(e); end
                3'd3: begin e.vec = in_multiplier; e.mask = '1; exp.push_back(e); end
                3'd4: begin e.sc = in_acc;         exp.push_back(e); end
                3'd5: begin e.sc = in_nonlin;      exp.push_back(e); end
                default: begin
                    for (int b = 0; b < NB; b++) begin
                        e        = blank();
                        e.is_idx = (b >= KB);
                        e.last   = (b == NB - 1);
                        e.beat   = BW'(b);
                        for (int j = 0; j < LANES; j++) begin
                            int el;
                            el = (b % KB) * LANES + j;
                            if (el < K) begin
                                e.vec[j]  = e.is_idx ? in_ksort_index[el] : in_ksort[el];
                                e.mask[j] = 1'b1;
                            end
                        end
                        exp.push_back(e);
                    end
                end
            endcase
        end
        sel   = s;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        sel   = 3'($urandom);
        chk("err_pulse", w_t'(err), w_t'(idle && !legal));
        foreach (exp[i]) q.push_back(exp[i]);
        if (idle && !legal) begin
            @(posedge clk);
            #1;
            chk("err_one_cycle", w_t'(err), '0);
        end
    endtask

    task automatic wait_idle(input int maxc);
        int n;
        n = 0;
        while (q.size() != 0 && n < maxc) begin
            @(posedge clk);
            #1;
            randomize_src();
            n++;
        end
        chk("drain_timeout", w_t'(q.size() == 0), w_t'(1'b1));
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, "_busy"},  w_t'(busy),         '0);
        chk({nm, "_valid"}, w_t'(out_valid),    '0);
        chk({nm, "_err"},   w_t'(err),          '0);
        chk({nm, "_vec"},   w_t'(out_vector),   '0);
        chk({nm, "_sc"},    w_t'(out_scalar),   '0);
        chk({nm, "_mask"},  w_t'(out_mask),     '0);
        chk({nm, "_idx"},   w_t'(out_is_index), '0);
        chk({nm, "_last"},  w_t'(out_last),     '0);
        chk({nm, "_beat"},  w_t'(out_beat),     '0);
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            rcnt++;
            case (rmode)
                0:       out_ready = 1'b1;
                1:       out_ready = 1'($urandom % 2);
                2:       out_ready = ((rcnt % 3) == 0);
                default: ;
            endcase
        end
    end

    beat_t mon_e;
    bit    hold_prev = 1'b0;
    logic [LANES-1:0][DW-1:0] hold_vec;
    logic [DW-1:0]            hold_sc;

    always @(negedge clk) begin
        if (rst) begin
            chk("valid_vs_model", w_t'(out_valid), w_t'(q.size() != 0));
            chk("busy_vs_valid", w_t'(busy), w_t'(out_valid));
            if (!out_valid) begin
                chk("idle_mask", w_t'(out_mask), '0);
                chk("idle_last", w_t'(out_last), '0);
            end else if (q.size() > 0) begin
                mon_e = q[0];
                chk("vector",   w_t'(out_vector),   w_t'(mon_e.vec));
                chk("scalar",   w_t'(out_scalar),   w_t'(mon_e.sc));
                chk("mask",     w_t'(out_mask),     w_t'(mon_e.mask));
                chk("is_index", w_t'(out_is_index), w_t'(mon_e.is_idx));
                chk("last",     w_t'(out_last),     w_t'(mon_e.last));
                chk("beat",     w_t'(out_beat),     w_t'(mon_e.beat));
            end
            if (hold_prev) begin
                chk("hold_valid", w_t'(out_valid), w_t'(1'b1));
                chk("hold_vec",   w_t'(out_vector), w_t'(hold_vec));
                chk("hold_sc",    w_t'(out_scalar), w_t'(hold_sc));
            end
            hold_prev = out_valid && !out_ready;
            hold_vec  = out_vector;
            hold_sc   = out_scalar;
            if (out_valid && out_ready && q.size() > 0) void'(q.pop_front());
        end else begin
            hold_prev = 1'b0;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst       = 1'b0;
        start     = 1'b0;
        sel       = 3'd0;
        out_ready = 1'b0;
        randomize_src();
        repeat (2) @(posedge clk);
        #1;
        chk_all_zero("reset");
        rst = 1'b1;
        @(posedge clk);
        #1;

        rmode     = 0;
        out_ready = 1'b1;
        for (int j = 0; j < LANES; j++) in_adder[j] = DW'(j + 100);
        issue(3'b010);
        wait_idle(10);
        chk("t1_busy_after", w_t'(busy), '0);

        rmode     = 3;
        out_ready = 1'b0;
        in_acc    = 32'hDEAD_BEEF;
        issue(3'b100);
        repeat (3) begin
            chk("t2_scalar_hold", w_t'(out_scalar), w_t'(32'hDEAD_BEEF));
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        chk("t2_scalar_last", w_t'(out_scalar), w_t'(32'hDEAD_BEEF));
        wait_idle(10);

        rmode = 0;
        for (int i = 0; i < K; i++) begin
            in_ksort[i]       = DW'(i);
            in_ksort_index[i] = DW'(1000 + i);
        end
        issue(3'b110);
        wait_idle(20);

        rmode = 2;
        for (int i = 0; i < K; i++) begin
            in_ksort[i]       = DW'(i * 7 + 3);
            in_ksort_index[i] = DW'(5000 - i);
        end
        issue(3'b110);
        wait_idle(60);

        rmode = 1;
        issue(3'b111);
        issue(3'b000);
        issue(3'b110);
        issue(3'b001);
        wait_idle(100);

        rmode = 0;
        issue(3'b110);
        @(posedge clk);
        #1;
        chk("t6_on_beat1", w_t'(out_beat), w_t'(1));
        rst = 1'b0;
        #1;
        q.delete();
        chk_all_zero("t6_reset");
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("t6_no_resume", w_t'(out_valid), '0);

        for (int n = 0; n < 40; n++) begin
            rmode = $urandom % 3;
            randomize_src();
            issue(3'($urandom));
            if ($urandom % 2) wait_idle(100);
        end
        wait_idle(100);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/result_sel_stream.md
Name: result_sel_stream

Overview:
Parametrised output selector and serializer at the back end of the PuDianNao functional-unit datapath. On a start pulse it snapshots one source: counter, adder or multiplier vector; acc or nonlin scalar; or the k-sort value/index arrays. It then streams the snapshot to the output buffer as LANES-wide beats under a valid/ready handshake. K-sort results of any K are split into multiple beats, values first and then indices, with lane masks on partial beats.

Parameters:
DW, 32, data word width (values and indices)
LANES, 16, vector output lanes per beat
K, 20, k-sort result count; any K >= 1
KBEATS, ceil(K/LANES), derived (localparam): beats per k-sort array
BW, clog2(2*KBEATS) (min 1), derived (localparam): beat counter width

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-low reset
start  in  1  request pulse; sampled only in IDLE
sel  in  3  source select, sampled with start
in_counter  in  LANES x DW  counter vector
in_adder  in  LANES x DW  adder vector
in_multiplier  in  LANES x DW  multiplier vector
in_acc  in  DW  accumulator scalar
in_nonlin  in  DW  nonlinear unit scalar
in_ksort  in  K x DW  k-sort values
in_ksort_index  in  K x DW  k-sort indices
busy  out  1  high while a transfer is in progress
out_valid  out  1  beat valid
out_ready  in  1  downstream accept
out_vector  out  LANES x DW  vector beat
out_scalar  out  DW  scalar beat
out_mask  out  LANES  per-lane valid
out_is_index  out  1  beat carries k-sort indices
out_last  out  1  final beat of the transfer
out_beat  out  BW  beat number within the transfer, from 0
err  out  1  one-cycle pulse on illegal sel

Behaviour:
- Reset: state IDLE. All outputs are 0, including busy, out_valid and err. Snapshot registers are don't-care.
- Reset asserted mid-transfer aborts the transfer. No further beats are produced after reset release.
- sel encoding: 001 counter, 010 adder, 011 multiplier, 100 acc, 101 nonlin, 110 ksort. Codes 000 and 111 are illegal.
- FSM states: IDLE, SEND.
- IDLE, start=1, legal sel:
  - Capture the selected source into snapshot registers. K-sort captures both arrays, 2K words.
  - Go to SEND. busy=1 and out_valid=1 from the next cycle, i.e. 1-cycle latency from start to first beat.
  - out_beat=0.
- IDLE, start=1, illegal sel: err=1 for the next cycle only. Stay in IDLE; no beat is produced.
- start in SEND is ignored. Sources may change after the start cycle; output comes only from the snapshot.
- Handshake:
  - A beat transfers on the edge where out_valid && out_ready.
  - All out_* signals are registered and hold stable while out_valid && !out_ready.
  - out_valid never drops before its handshake.
- Vector modes: one beat. out_vector = snapshot, out_mask all ones, out_scalar=0, out_last=1, out_is_index=0.
- Scalar modes: one beat. out_scalar = snapshot, out_vector=0, out_mask=0, out_last=1, out_is_index=0.
- K-sort mode: 2*KBEATS beats, with b = out_beat.
  - b < KBEATS: out_is_index=0. Lane j carries value[b*LANES+j].
  - b >= KBEATS: out_is_index=1. Lane j carries index[(b-KBEATS)*LANES+j].
  - A lane whose element number is >= K has data 0 and mask 0.
  - out_last=1 only on beat 2*KBEATS-1. out_scalar=0 throughout.
- End of transfer: on the handshake of the last beat, go to IDLE. out_valid, out_last, out_mask and busy are 0 the next cycle. A start in that cycle is accepted, so back-to-back transfers have a 1-cycle gap.
- out_ready held high gives one beat per cycle. out_ready may toggle arbitrarily.

Decomposition:
- Package pudiannao_sel_pkg:
  - sel_e enum with the codes above
  - state_e {IDLE, SEND}
  - DW default constant
- Sub-module ksort_beat_slicer (combinational): takes snapshot arrays and beat number; returns the LANES-lane slice, mask and is_index.
- Top-level result_sel_stream holds the FSM, snapshot registers and output registers.

Test Plan:
1. Reset, then start with sel=010, in_adder[j]=j+100, out_ready=1 -> next cycle out_valid=1, out_vector[j]=j+100, out_mask=16'hFFFF, out_last=1; following cycle busy=0.
2. start with sel=100, in_acc=32'hDEAD_BEEF, out_ready=0 for 3 cycles then 1 -> out_scalar=DEADBEEF stable for 4 cycles, out_mask=0, single beat.
3. K=20, start with sel=110, value[i]=i, index[i]=1000+i, out_ready=1 -> 4 beats in 4 cycles:
   - beat 0: values 0..15, mask FFFF
   - beat 1: values 16..19, mask 000F, lanes 4-15 = 0
   - beats 2-3: indices 1000..1019 with the same masks, out_is_index=1
   - out_last on beat 3 only
4. Same as 3 with out_ready toggling 1,0,0,1,... and in_ksort changed after start -> no beat lost or duplicated; data equals the start-cycle snapshot.
5. start with sel=111 and with sel=000 -> err pulses one cycle each, out_valid stays 0. start with sel=001 during a k-sort burst -> ignored.
6. Deassert rst during beat 1 of a k-sort burst -> all outputs 0 immediately; after release, out_valid stays 0 until a new start.
